ysyx_25020037_gpr_csr_sb: RTL and testbench
===========================================

Name: ysyx_25020037_gpr_csr_sb

Overview:
Parametrised successor to the core's GPR/CSR register file. It adds the following to the existing bank:
- a configurable register count (RV32E or RV32I);
- a per-register scoreboard that stalls issue on RAW/WAW hazards;
- writeback-to-read bypass;
- a full machine trap CSR set with writable mcause/mscratch and trap-redirect output.

It sits between the IDU (issue side) and the WBU (commit side) and feeds operands to the EXU.

Parameters:
NREG, 16, number of GPRs: 16 (RV32E) or 32 (RV32I); x0 is hardwired to 0.
XLEN, 32, data width of GPRs and CSRs.
AW, $clog2(NREG), register-index width (derived, not overridden).
ECALL_CAUSE, 32'hb, mcause value written by ecall.

Ports:
clk  in  1  core clock.
rst_n  in  1  asynchronous active-low reset.
iss_valid  in  1  IDU presents an instruction.
iss_ready  out  1  no hazard; instruction accepted this cycle when iss_valid=1.
iss_rs1, iss_rs2  in  AW  source indices.
iss_rd  in  AW  destination index.
iss_rd_wen  in  1  instruction writes rd.
iss_csr_rd  in  1  instruction reads a CSR.
iss_csr_wr  in  1  instruction writes a CSR (also ecall/mret).
iss_csr_addr  in  12  CSR address; ecall reads mtvec, mret reads mepc.
iss_ecall, iss_mret  in  1  decoded ecall/mret.
rs1_data, rs2_data  out  XLEN  operand values (bypassed).
csr_rdata  out  XLEN  CSR read value.
wb_valid  in  1  WBU commit strobe.
wb_rd  in  AW  commit destination.
wb_wen  in  1  commit writes GPR.
wb_data  in  XLEN  GPR write data.
wb_csr_wen  in  1  commit writes the CSR at wb_csr_addr.
wb_csr_addr  in  12  commit CSR address.
wb_csr_data  in  XLEN  CSR write data.
wb_ecall, wb_mret  in  1  trap entry / return commit.
wb_pc  in  XLEN  PC of committing instruction (becomes mepc on ecall).
redirect_valid  out  1  registered; pulses 1 cycle after an ecall/mret commit.
redirect_pc  out  XLEN  mtvec (ecall) or mepc (mret).
flush  in  1  pipeline flush; clears the scoreboard.

Behaviour:
- Reset (async on rst_n low):
  - all GPRs 0, busy bits 0, csr_busy 0;
  - mstatus=32'h1800; mtvec, mepc, mcause, mscratch = 0;
  - redirect_valid=0, redirect_pc=0.
  - After reset iss_ready=1.
- Reads are combinational. rsN=0 returns 0. Unknown CSR addresses read 0. mvendorid=32'h79737978 and marchid=32'h017DC685 are read-only; writes to them are ignored.
- Bypass: if wb_valid & wb_wen & wb_rd==rsN & rsN!=0, rsN_data=wb_data. The CSR path likewise bypasses wb_csr_data on an address match.
- Hazards: iss_ready = 0 when any of the following holds, with a matching same-cycle commit counting as not busy:
  - busy[rs1] with rs1!=0;
  - busy[rs2] with rs2!=0;
  - iss_rd_wen & busy[rd];
  - (iss_csr_rd | iss_csr_wr | iss_ecall | iss_mret) & csr_busy.
- Accept (iss_valid & iss_ready):
  - sets busy[rd] if iss_rd_wen & rd!=0;
  - sets csr_busy if iss_csr_wr | iss_ecall | iss_mret.
- Commit (wb_valid):
  - writes the GPR if wb_wen & wb_rd!=0, and clears busy[wb_rd];
  - clears csr_busy on wb_csr_wen | wb_ecall | wb_mret.
- Same-cycle set and clear of the same busy bit: set wins.
- flush: clears all busy bits and csr_busy, and overrides a same-cycle issue set. A commit in the same cycle still writes.
- ecall commit:
  - mepc<=wb_pc, mcause<=ECALL_CAUSE;
  - mstatus.MPIE(7)<=MIE(3), MIE<=0, MPP(12:11)<=2'b11.
- mret commit: MIE<=MPIE, MPIE<=1, MPP<=2'b00.
- wb_ecall and wb_mret both set: ecall wins. A trap commit overrides wb_csr_wen to mstatus/mepc/mcause in the same cycle.
- Redirect: redirect_valid<=wb_valid&(wb_ecall|wb_mret) and redirect_pc is registered in the same cycle. For ecall it is the pre-commit mtvec; for mret it is the pre-commit mepc.
- Reset mid-operation: everything returns to the reset state immediately. In-flight commits are lost.

Optional Feature:
YSYX_25020037_GPR_BYPASS_EN:
- Defined: same-cycle wb→read bypass as above; a dependent instruction issues in the commit cycle.
- Undefined: no bypass paths. A commit clears busy only at the clock edge, so the dependent instruction stalls one extra cycle. Reads always come from the array.

Decomposition:
- Package ysyx_25020037_pkg holds:
  - CSR address constants (MSTATUS 300, MTVEC 305, MEPC 341, MCAUSE 342, MSCRATCH 340, MVENDORID F11, MARCHID F12);
  - mstatus bit positions (MIE 3, MPIE 7, MPP 12:11);
  - reset values and vendor/arch IDs.
- One sub-module, ysyx_25020037_scoreboard: busy-bit vector plus csr_busy, set/clear/flush logic, and the iss_ready computation.

Test Plan:
- Reset, then issue rd=5, then issue rs1=5 without commit → iss_ready=0. Commit wb_rd=5, wb_data=32'h1234 → same cycle, iss_ready=1 and rs1_data=32'h1234 (bypass build); next cycle iss_ready=1 (non-bypass build).
- Commit wb_rd=0, wb_data=32'hFFFF_FFFF → rs1=0 reads 0; busy[0] never set.
- mtvec=32'h8000_0100 committed, then ecall commit with wb_pc=32'h8000_0040 → next cycle redirect_valid=1, redirect_pc=32'h8000_0100. mepc=32'h8000_0040, mcause=32'hb, mstatus=32'h1800.
- After the ecall above, mret commit → redirect_pc=32'h8000_0040, mstatus=32'h0000_0080.
- Issue rd=7, then flush, then issue rs2=7 → iss_ready=1 on the cycle after flush. A concurrent issue+flush leaves busy clear.
- NREG=32: write x31=32'hA5A5_A5A5, read rs2=31 → 32'hA5A5_A5A5. Assert rst_n low mid-stall → iss_ready=1 and x31=0 immediately.

Source files
------------

// File: rtl/ysyx_25020037_pkg.sv
// Shared constants for the GPR/CSR bank: CSR addresses, mstatus layout, reset values, IDs.
package ysyx_25020037_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;

    localparam logic [31:0] MSTATUS_RST   = 32'h0000_1800;
    localparam logic [31:0] MVENDORID_VAL = 32'h7973_7978;
    localparam logic [31:0] MARCHID_VAL   = 32'h017D_C685;

    typedef enum logic [1:0] {
        TRAP_NONE,
        TRAP_ECALL,
        TRAP_MRET
    } trap_e;

    // ecall takes priority when both trap strobes are raised together
    function automatic trap_e trap_kind(input logic ecall, input logic mret);
        if (ecall) return TRAP_ECALL;
        if (mret)  return TRAP_MRET;
        return TRAP_NONE;
    endfunction

endpackage

// File: rtl/ysyx_25020037_scoreboard.sv
// Per-GPR busy bits plus a single CSR busy flag; produces the issue-ready decision.
// Build option YSYX_25020037_GPR_BYPASS_EN lets a same-cycle commit release a hazard.
module ysyx_25020037_scoreboard
    import ysyx_25020037_pkg::*;
#(
    parameter int unsigned NREG = 16,
    localparam int unsigned AW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_rs1,
    input  logic [AW-1:0] iss_rs2,
    input  logic [AW-1:0] iss_rd,
    input  logic          iss_rd_wen,
    input  logic          iss_csr_any,
    input  logic          iss_csr_set,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_rd,
    input  logic          wb_wen,
    input  logic          wb_csr_clr,
    input  logic          flush,
    output logic          iss_ready
);

    logic [NREG-1:0] busy, busy_eff, clr_mask, set_mask;
    logic            csr_busy, csr_busy_eff, accept;

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (wb_valid && wb_wen)
            clr_mask[wb_rd] = 1'b1;
        if (accept && iss_rd_wen && iss_rd != '0)
            set_mask[iss_rd] = 1'b1;
    end

`ifdef YSYX_25020037_GPR_BYPASS_EN
    assign busy_eff     = busy & ~clr_mask;
    assign csr_busy_eff = csr_busy & ~wb_csr_clr;
`else
    assign busy_eff     = busy;
    assign csr_busy_eff = csr_busy;
`endif

    always_comb begin
        iss_ready = 1'b1;
        if (iss_rs1 != '0 && busy_eff[iss_rs1]) iss_ready = 1'b0;
        if (iss_rs2 != '0 && busy_eff[iss_rs2]) iss_ready = 1'b0;
        if (iss_rd_wen && busy_eff[iss_rd])     iss_ready = 1'b0;
        if (iss_csr_any && csr_busy_eff)        iss_ready = 1'b0;
    end

    assign accept = iss_valid & iss_ready;

    // set is applied after clear so a same-cycle set wins; flush beats both
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            csr_busy <= 1'b0;
        end else if (flush) begin
            busy     <= '0;
            csr_busy <= 1'b0;
        end else begin
            busy     <= (busy & ~clr_mask) | set_mask;
            csr_busy <= (csr_busy & ~wb_csr_clr) | (accept & iss_csr_set);
        end
    end

endmodule

// File: rtl/ysyx_25020037_gpr_csr_sb.sv
// GPR bank, machine trap CSRs and redirect, fronted by the issue scoreboard.
// Build option YSYX_25020037_GPR_BYPASS_EN enables writeback-to-read bypass.
module ysyx_25020037_gpr_csr_sb
    import ysyx_25020037_pkg::*;
#(
    parameter int unsigned NREG         = 16,
    parameter int unsigned XLEN         = 32,
    parameter logic [XLEN-1:0] ECALL_CAUSE = XLEN'(32'hb),
    localparam int unsigned AW          = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_valid,
    output logic            iss_ready,
    input  logic [AW-1:0]   iss_rs1,
    input  logic [AW-1:0]   iss_rs2,
    input  logic [AW-1:0]   iss_rd,
    input  logic            iss_rd_wen,
    input  logic            iss_csr_rd,
    input  logic            iss_csr_wr,
    input  logic [11:0]     iss_csr_addr,
    input  logic            iss_ecall,
    input  logic            iss_mret,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] csr_rdata,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic            wb_wen,
    input  logic [XLEN-1:0] wb_data,
    input  logic            wb_csr_wen,
    input  logic [11:0]     wb_csr_addr,
    input  logic [XLEN-1:0] wb_csr_data,
    input  logic            wb_ecall,
    input  logic            wb_mret,
    input  logic [XLEN-1:0] wb_pc,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            flush
);

    logic [XLEN-1:0] gpr [NREG];
    logic [XLEN-1:0] mstatus, mtvec, mepc, mcause, mscratch;
    logic [XLEN-1:0] mstatus_n, mtvec_n, mepc_n, mcause_n, mscratch_n;
    logic            gpr_we, csr_we;
    logic [11:0]     csr_raddr;
    trap_e           trap;

    ysyx_25020037_scoreboard #(.NREG(NREG)) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .iss_valid  (iss_valid),
        .iss_rs1    (iss_rs1),
        .iss_rs2    (iss_rs2),
        .iss_rd     (iss_rd),
        .iss_rd_wen (iss_rd_wen),
        .iss_csr_any(iss_csr_rd | iss_csr_wr | iss_ecall | iss_mret),
        .iss_csr_set(iss_csr_wr | iss_ecall | iss_mret),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_wen     (wb_wen),
        .wb_csr_clr (wb_valid & (wb_csr_wen | wb_ecall | wb_mret)),
        .flush      (flush),
        .iss_ready  (iss_ready)
    );

    assign gpr_we = wb_valid & wb_wen & (wb_rd != '0);
    assign csr_we = wb_valid & wb_csr_wen;
    assign trap   = wb_valid ? trap_kind(wb_ecall, wb_mret) : TRAP_NONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++)
                gpr[i] <= '0;
        end else if (gpr_we) begin
            gpr[wb_rd] <= wb_data;
        end
    end

`ifdef YSYX_25020037_GPR_BYPASS_EN
    assign rs1_data = (iss_rs1 == '0) ? '0 : (gpr_we && wb_rd == iss_rs1) ? wb_data : gpr[iss_rs1];
    assign rs2_data = (iss_rs2 == '0) ? '0 : (gpr_we && wb_rd == iss_rs2) ? wb_data : gpr[iss_rs2];
`else
    assign rs1_data = (iss_rs1 == '0) ? '0 : gpr[iss_rs1];
    assign rs2_data = (iss_rs2 == '0) ? '0 : gpr[iss_rs2];
`endif

    // A trap commit owns mstatus/mepc/mcause; software writes to them are dropped that cycle.
    always_comb begin
        mstatus_n  = mstatus;
        mtvec_n    = mtvec;
        mepc_n     = mepc;
        mcause_n   = mcause;
        mscratch_n = mscratch;
        if (csr_we) begin
            case (wb_csr_addr)
                CSR_MSTATUS:  if (trap == TRAP_NONE) mstatus_n = wb_csr_data;
                CSR_MTVEC:    mtvec_n = wb_csr_data;
                CSR_MEPC:     if (trap == TRAP_NONE) mepc_n = wb_csr_data;
                CSR_MCAUSE:   if (trap == TRAP_NONE) mcause_n = wb_csr_data;
                CSR_MSCRATCH: mscratch_n = wb_csr_data;
                default: ;
            endcase
        end
        case (trap)
            TRAP_ECALL: begin
                mepc_n                          = wb_pc;
                mcause_n                        = ECALL_CAUSE;
                mstatus_n[MSTATUS_MPIE]         = mstatus[MSTATUS_MIE];
                mstatus_n[MSTATUS_MIE]          = 1'b0;
                mstatus_n[MSTATUS_MPP_LO +: 2]  = 2'b11;
            end
            TRAP_MRET: begin
                mstatus_n[MSTATUS_MIE]          = mstatus[MSTATUS_MPIE];
                mstatus_n[MSTATUS_MPIE]         = 1'b1;
                mstatus_n[MSTATUS_MPP_LO +: 2]  = 2'b00;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus        <= XLEN'(MSTATUS_RST);
            mtvec          <= '0;
            mepc           <= '0;
            mcause         <= '0;
            mscratch       <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            mstatus        <= mstatus_n;
            mtvec          <= mtvec_n;
            mepc           <= mepc_n;
            mcause         <= mcause_n;
            mscratch       <= mscratch_n;
            redirect_valid <= (trap != TRAP_NONE);
            if (trap != TRAP_NONE)
                redirect_pc <= (trap == TRAP_ECALL) ? mtvec : mepc;
        end
    end

    function automatic logic [XLEN-1:0] csr_mux(input logic [11:0] a, input logic [XLEN-1:0] st,
                                                input logic [XLEN-1:0] tv, input logic [XLEN-1:0] ep,
                                                input logic [XLEN-1:0] ca, input logic [XLEN-1:0] sc);
        case (a)
            CSR_MSTATUS:   return st;
            CSR_MTVEC:     return tv;
            CSR_MEPC:      return ep;
            CSR_MCAUSE:    return ca;
            CSR_MSCRATCH:  return sc;
            CSR_MVENDORID: return XLEN'(MVENDORID_VAL);
            CSR_MARCHID:   return XLEN'(MARCHID_VAL);
            default:       return '0;
        endcase
    endfunction

    assign csr_raddr = iss_ecall ? CSR_MTVEC : iss_mret ? CSR_MEPC : iss_csr_addr;

`ifdef YSYX_25020037_GPR_BYPASS_EN
    // next-state values equal the current ones unless a commit is landing this cycle
    assign csr_rdata = csr_mux(csr_raddr, mstatus_n, mtvec_n, mepc_n, mcause_n, mscratch_n);
`else
    assign csr_rdata = csr_mux(csr_raddr, mstatus, mtvec, mepc, mcause, mscratch);
`endif

endmodule

// File: tb/tb_ysyx_25020037_gpr_csr_sb.sv
// Self-checking bench: directed vector table, reset-mid-stall sequence, random run vs. reference model.
module tb_ysyx_25020037_gpr_csr_sb;
    import ysyx_25020037_pkg::*;

`ifdef YSYX_25020037_GPR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk, rst_n;
    logic        iss_valid, iss_ready, iss_rd_wen, iss_csr_rd, iss_csr_wr, iss_ecall, iss_mret;
    logic [4:0]  iss_rs1, iss_rs2, iss_rd, wb_rd;
    logic [11:0] iss_csr_addr, wb_csr_addr;
    logic [31:0] rs1_data, rs2_data, csr_rdata, wb_data, wb_csr_data, wb_pc, redirect_pc;
    logic        wb_valid, wb_wen, wb_csr_wen, wb_ecall, wb_mret, redirect_valid, flush;

    ysyx_25020037_gpr_csr_sb #(.NREG(32), .XLEN(32), .ECALL_CAUSE(32'hb)) dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_rd_wen(iss_rd_wen),
        .iss_csr_rd(iss_csr_rd), .iss_csr_wr(iss_csr_wr), .iss_csr_addr(iss_csr_addr),
        .iss_ecall(iss_ecall), .iss_mret(iss_mret),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .csr_rdata(csr_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_data(wb_data),
        .wb_csr_wen(wb_csr_wen), .wb_csr_addr(wb_csr_addr), .wb_csr_data(wb_csr_data),
        .wb_ecall(wb_ecall), .wb_mret(wb_mret), .wb_pc(wb_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [4:0]  rs1, rs2, rd;
        logic        rd_wen, csr_rd, csr_wr;
        logic [11:0] caddr;
        logic        ecall, mret;
        logic        wv;
        logic [4:0]  wrd;
        logic        wwen;
        logic [31:0] wdata;
        logic        wcwen;
        logic [11:0] wcaddr;
        logic [31:0] wcdata;
        logic        wecall, wmret;
        logic [31:0] wpc;
        logic        flush;
        logic        e_ready;
        logic [31:0] e_rs1, e_rs2, e_csr;
        logic        e_rv;
        logic [31:0] e_rpc;
    } vec_t;

    int errors = 0;
    int checks = 0;

    function automatic vec_t blank();
        vec_t b;
        b = '{default: '0};
        b.e_ready = 1'b1;
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        iss_valid = x.iv;        iss_rs1 = x.rs1;          iss_rs2 = x.rs2;
        iss_rd = x.rd;           iss_rd_wen = x.rd_wen;    iss_csr_rd = x.csr_rd;
        iss_csr_wr = x.csr_wr;   iss_csr_addr = x.caddr;   iss_ecall = x.ecall;
        iss_mret = x.mret;       wb_valid = x.wv;          wb_rd = x.wrd;
        wb_wen = x.wwen;         wb_data = x.wdata;        wb_csr_wen = x.wcwen;
        wb_csr_addr = x.wcaddr;  wb_csr_data = x.wcdata;   wb_ecall = x.wecall;
        wb_mret = x.wmret;       wb_pc = x.wpc;            flush = x.flush;
    endtask

    function automatic logic [31:0] csr_val(input logic [11:0] a, input logic [31:0] st, input logic [31:0] tv,
                                            input logic [31:0] ep, input logic [31:0] ca, input logic [31:0] sc);
        if (a == 12'h300) return st;
        if (a == 12'h305) return tv;
        if (a == 12'h341) return ep;
        if (a == 12'h342) return ca;
        if (a == 12'h340) return sc;
        if (a == 12'hF11) return 32'h7973_7978;
        if (a == 12'hF12) return 32'h017D_C685;
        return 32'h0;
    endfunction

    vec_t        tbl[$];
    vec_t        v, r;
    logic [31:0] m_gpr [32];
    bit          m_busy [32];
    bit          m_cbusy, m_rv, exp_ready, accept, trap;
    logic [31:0] m_rpc, m_st, m_tv, m_ep, m_ca, m_sc, n_st, n_tv, n_ep, n_ca, n_sc, e1, e2;
    logic [11:0] raddr;
    logic [11:0] caddrs [9] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h340, 12'hF11, 12'hF12, 12'h000, 12'h7C0};

    initial begin
        // ---------------- directed vector table ----------------
        v = blank(); v.caddr = 12'hF11; v.e_csr = 32'h7973_7978; tbl.push_back(v);                          // 0
        v = blank(); v.iv = 1; v.rd = 5; v.rd_wen = 1; tbl.push_back(v);                                    // 1
        v = blank(); v.iv = 1; v.rs1 = 5; v.e_ready = 0; tbl.push_back(v);                                  // 2
        v = blank(); v.iv = 1; v.rs1 = 5; v.wv = 1; v.wrd = 5; v.wwen = 1; v.wdata = 32'h1234;
        v.e_ready = BYP; v.e_rs1 = BYP ? 32'h1234 : 32'h0; tbl.push_back(v);                                // 3
        v = blank(); v.iv = 1; v.rs1 = 5; v.e_rs1 = 32'h1234; tbl.push_back(v);                             // 4
        v = blank(); v.iv = 1; v.rd = 0; v.rd_wen = 1; v.wv = 1; v.wrd = 0; v.wwen = 1;
        v.wdata = 32'hFFFF_FFFF; tbl.push_back(v);                                                          // 5
        v = blank(); v.iv = 1; v.rd = 0; v.rd_wen = 1; v.caddr = 12'h123; tbl.push_back(v);                 // 6
        v = blank(); v.wv = 1; v.wcwen = 1; v.wcaddr = 12'h305; v.wcdata = 32'h8000_0100;
        v.caddr = 12'h305; v.e_csr = BYP ? 32'h8000_0100 : 32'h0; tbl.push_back(v);                         // 7
        v = blank(); v.caddr = 12'h305; v.e_csr = 32'h8000_0100; v.wv = 1; v.wecall = 1;
        v.wpc = 32'h8000_0040; tbl.push_back(v);                                                            // 8
        v = blank(); v.caddr = 12'h341; v.e_csr = 32'h8000_0040; v.e_rv = 1; v.e_rpc = 32'h8000_0100;
        tbl.push_back(v);                                                                                   // 9
        v = blank(); v.caddr = 12'h300; v.e_csr = 32'h1800; tbl.push_back(v);                               // 10
        v = blank(); v.caddr = 12'h342; v.e_csr = 32'hb; v.wv = 1; v.wmret = 1; tbl.push_back(v);           // 11
        v = blank(); v.caddr = 12'h300; v.e_csr = 32'h80; v.e_rv = 1; v.e_rpc = 32'h8000_0040;
        v.wv = 1; v.wcwen = 1; v.wcaddr = 12'hF12; v.wcdata = 32'h0; tbl.push_back(v);                      // 12
        v = blank(); v.caddr = 12'hF12; v.e_csr = 32'h017D_C685; v.iv = 1; v.csr_wr = 1; tbl.push_back(v); // 13
        v = blank(); v.iv = 1; v.csr_rd = 1; v.caddr = 12'h340; v.e_ready = 0; tbl.push_back(v);            // 14
        v = blank(); v.iv = 1; v.csr_rd = 1; v.caddr = 12'h340; v.wv = 1; v.wcwen = 1; v.wcaddr = 12'h340;
        v.wcdata = 32'hDEAD_BEEF; v.e_ready = BYP; v.e_csr = BYP ? 32'hDEAD_BEEF : 32'h0; tbl.push_back(v); // 15
        v = blank(); v.iv = 1; v.csr_rd = 1; v.caddr = 12'h340; v.e_csr = 32'hDEAD_BEEF; tbl.push_back(v); // 16
        v = blank(); v.iv = 1; v.rd = 7; v.rd_wen = 1; tbl.push_back(v);                                    // 17
        v = blank(); v.iv = 1; v.rs2 = 7; v.flush = 1; v.e_ready = 0; tbl.push_back(v);                     // 18
        v = blank(); v.iv = 1; v.rs2 = 7; v.rd = 9; v.rd_wen = 1; v.flush = 1; tbl.push_back(v);            // 19
        v = blank(); v.iv = 1; v.rs1 = 9; tbl.push_back(v);                                                 // 20
        v = blank(); v.iv = 1; v.rs2 = 31; v.wv = 1; v.wrd = 31; v.wwen = 1; v.wdata = 32'hA5A5_A5A5;
        v.e_rs2 = BYP ? 32'hA5A5_A5A5 : 32'h0; tbl.push_back(v);                                            // 21
        v = blank(); v.iv = 1; v.rs2 = 31; v.rd = 31; v.rd_wen = 1; v.e_rs2 = 32'hA5A5_A5A5; tbl.push_back(v); // 22
        v = blank(); v.iv = 1; v.rs2 = 31; v.e_ready = 0; v.e_rs2 = 32'hA5A5_A5A5; tbl.push_back(v);        // 23

        rst_n = 1'b0;
        v = blank(); v.caddr = 12'h300; drive(v);
        #12;
        chk("reset ready", 32'(iss_ready), 32'h1);
        chk("reset redirect_valid", 32'(redirect_valid), 32'h0);
        chk("reset redirect_pc", redirect_pc, 32'h0);
        chk("reset mstatus", csr_rdata, 32'h1800);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("row%0d ready", i), 32'(iss_ready), 32'(tbl[i].e_ready));
            chk($sformatf("row%0d rs1_data", i), rs1_data, tbl[i].e_rs1);
            chk($sformatf("row%0d rs2_data", i), rs2_data, tbl[i].e_rs2);
            chk($sformatf("row%0d csr_rdata", i), csr_rdata, tbl[i].e_csr);
            chk($sformatf("row%0d redirect_valid", i), 32'(redirect_valid), 32'(tbl[i].e_rv));
            if (tbl[i].e_rv)
                chk($sformatf("row%0d redirect_pc", i), redirect_pc, tbl[i].e_rpc);
        end

        // reset asserted while the rs2=31 stall is still being presented
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midreset ready", 32'(iss_ready), 32'h1);
        chk("midreset x31", rs2_data, 32'h0);
        chk("midreset redirect_valid", 32'(redirect_valid), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        v = blank(); v.caddr = 12'h305; drive(v); #1;
        chk("postreset mtvec", csr_rdata, 32'h0);
        v.caddr = 12'h340; drive(v); #1;
        chk("postreset mscratch", csr_rdata, 32'h0);

        // ---------------- randomized run vs. reference model ----------------
        rst_n = 1'b0;
        drive(blank());
        for (int i = 0; i < 32; i++) begin m_gpr[i] = 32'h0; m_busy[i] = 1'b0; end
        m_cbusy = 0; m_rv = 0; m_rpc = 32'h0;
        m_st = 32'h1800; m_tv = 32'h0; m_ep = 32'h0; m_ca = 32'h0; m_sc = 32'h0;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            r = blank();
            r.iv     = ($urandom_range(3) != 0);
            r.rs1    = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(5));
            r.rs2    = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(5));
            r.rd     = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(5));
            r.rd_wen = ($urandom_range(1) == 0);
            r.csr_rd = ($urandom_range(3) == 0);
            r.csr_wr = ($urandom_range(5) == 0);
            r.caddr  = caddrs[$urandom_range(8)];
            r.ecall  = ($urandom_range(15) == 0);
            r.mret   = ($urandom_range(15) == 0);
            r.wv     = ($urandom_range(1) == 0);
            r.wrd    = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(5));
            r.wwen   = ($urandom_range(1) == 0);
            r.wdata  = $urandom;
            r.wcwen  = ($urandom_range(3) == 0);
            r.wcaddr = caddrs[$urandom_range(8)];
            r.wcdata = $urandom;
            r.wecall = ($urandom_range(11) == 0);
            r.wmret  = ($urandom_range(11) == 0);
            r.wpc    = $urandom;
            r.flush  = ($urandom_range(19) == 0);
            drive(r);
            #1;

            // issue hazard: a register is held while its busy flag stands, unless bypass lets the commit release it now
            exp_ready = 1'b1;
            if (r.rs1 != 0 && m_busy[r.rs1] && !(BYP && r.wv && r.wwen && r.wrd == r.rs1)) exp_ready = 1'b0;
            if (r.rs2 != 0 && m_busy[r.rs2] && !(BYP && r.wv && r.wwen && r.wrd == r.rs2)) exp_ready = 1'b0;
            if (r.rd_wen && m_busy[r.rd] && !(BYP && r.wv && r.wwen && r.wrd == r.rd))     exp_ready = 1'b0;
            if ((r.csr_rd || r.csr_wr || r.ecall || r.mret) && m_cbusy &&
                !(BYP && r.wv && (r.wcwen || r.wecall || r.wmret)))                        exp_ready = 1'b0;

            e1 = (r.rs1 == 0) ? 32'h0 : (BYP && r.wv && r.wwen && r.wrd == r.rs1) ? r.wdata : m_gpr[r.rs1];
            e2 = (r.rs2 == 0) ? 32'h0 : (BYP && r.wv && r.wwen && r.wrd == r.rs2) ? r.wdata : m_gpr[r.rs2];

            n_st = m_st; n_tv = m_tv; n_ep = m_ep; n_ca = m_ca; n_sc = m_sc;
            trap = r.wv && (r.wecall || r.wmret);
            if (r.wv && r.wcwen) begin
                if (r.wcaddr == 12'h305) n_tv = r.wcdata;
                if (r.wcaddr == 12'h340) n_sc = r.wcdata;
                if (!trap && r.wcaddr == 12'h300) n_st = r.wcdata;
                if (!trap && r.wcaddr == 12'h341) n_ep = r.wcdata;
                if (!trap && r.wcaddr == 12'h342) n_ca = r.wcdata;
            end
            if (r.wv && r.wecall) begin
                n_ep = r.wpc; n_ca = 32'hb;
                n_st = (m_st & ~32'h0000_1888) | 32'h0000_1800 | (m_st[3] ? 32'h80 : 32'h0);
            end else if (r.wv && r.wmret) begin
                n_st = (m_st & ~32'h0000_1888) | 32'h80 | (m_st[7] ? 32'h8 : 32'h0);
            end

            raddr = r.ecall ? 12'h305 : r.mret ? 12'h341 : r.caddr;
            chk($sformatf("rnd%0d ready", c), 32'(iss_ready), 32'(exp_ready));
            chk($sformatf("rnd%0d rs1_data", c), rs1_data, e1);
            chk($sformatf("rnd%0d rs2_data", c), rs2_data, e2);
            chk($sformatf("rnd%0d csr_rdata", c), csr_rdata,
                BYP ? csr_val(raddr, n_st, n_tv, n_ep, n_ca, n_sc) : csr_val(raddr, m_st, m_tv, m_ep, m_ca, m_sc));
            chk($sformatf("rnd%0d redirect_valid", c), 32'(redirect_valid), 32'(m_rv));
            if (m_rv)
                chk($sformatf("rnd%0d redirect_pc", c), redirect_pc, m_rpc);

            // advance the model to the state after the coming clock edge
            accept = r.iv && exp_ready;
            if (r.wv && r.wwen && r.wrd != 0) m_gpr[r.wrd] = r.wdata;
            if (r.flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
                m_cbusy = 1'b0;
            end else begin
                if (r.wv && r.wwen) m_busy[r.wrd] = 1'b0;
                if (accept && r.rd_wen && r.rd != 0) m_busy[r.rd] = 1'b1;
                if (r.wv && (r.wcwen || r.wecall || r.wmret)) m_cbusy = 1'b0;
                if (accept && (r.csr_wr || r.ecall || r.mret)) m_cbusy = 1'b1;
            end
            m_rv = trap;
            if (trap) m_rpc = r.wecall ? m_tv : m_ep;
            m_st = n_st; m_tv = n_tv; m_ep = n_ep; m_ca = n_ca; m_sc = n_sc;
            @(posedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
